// File: rtl/div_ctrl_pkg.sv
// Shared defines for the EXE-stage divider and its sequencing controller:
// bus widths, state encodings, hold lengths and a small arithmetic helper.
package div_ctrl_pkg;

   localparam int REG_BUS        = 32;
   localparam int DOUBLE_REG_BUS = 64;

   typedef enum logic [1:0] {
      CTRL_IDLE    = 2'b00,
      CTRL_BUSY    = 2'b01,
      CTRL_RELEASE = 2'b10,
      CTRL_DRAIN   = 2'b11
   } ctrl_state_t;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_t;

   localparam logic [1:0] RELEASE_CYCLES = 2'd1;
   localparam logic [1:0] DRAIN_CYCLES   = 2'd2;
   localparam logic [5:0] DIV_STEPS      = 6'd32;

   function automatic logic [REG_BUS-1:0] cond_neg(input logic neg, input logic [REG_BUS-1:0] v);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_ctrl_div.sv
// Radix-2 restoring divider (DIV/DIVU). Runs 32 steps plus a sign fix-up
// cycle; the fix-up re-reads operand signs, so inputs must stay stable.
module div_ctrl_div
   import div_ctrl_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      cancel,
   input  logic                      sign,
   input  logic [REG_BUS-1:0]        op1,
   input  logic [REG_BUS-1:0]        op2,
   output logic [DOUBLE_REG_BUS-1:0] result,
   output logic                      done
);

   div_state_t                state_r;
   logic [5:0]                cnt_r;
   logic [REG_BUS-1:0]        rem_r;
   logic [REG_BUS-1:0]        quo_r;
   logic [REG_BUS-1:0]        dvs_r;
   logic [DOUBLE_REG_BUS-1:0] result_r;
   logic [REG_BUS:0]          shifted_s;
   logic [REG_BUS+1:0]        trial_s;

   assign shifted_s = {rem_r, quo_r[REG_BUS-1]};
   assign trial_s   = {1'b0, shifted_s} - {2'b00, dvs_r};
   assign result    = result_r;
   assign done      = (state_r == DIV_END);

   // Divider state machine and datapath; by-zero path deliberately ignores cancel.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r  <= DIV_FREE;
         cnt_r    <= 6'd0;
         rem_r    <= 32'd0;
         quo_r    <= 32'd0;
         dvs_r    <= 32'd0;
         result_r <= 64'd0;
      end else begin
         case (state_r)
            DIV_FREE: begin
               if (en && !cancel) begin
                  if (op2 == 32'd0) begin
                     state_r <= DIV_BY_ZERO;
                  end else begin
                     state_r <= DIV_ON;
                     cnt_r   <= 6'd0;
                     rem_r   <= 32'd0;
                     quo_r   <= cond_neg(sign && op1[REG_BUS-1], op1);
                     dvs_r   <= cond_neg(sign && op2[REG_BUS-1], op2);
                  end
               end
            end
            DIV_BY_ZERO: begin
               result_r <= 64'd0;
               state_r  <= DIV_END;
            end
            DIV_ON: begin
               if (cancel) begin
                  state_r <= DIV_FREE;
               end else if (cnt_r != DIV_STEPS) begin
                  if (trial_s[REG_BUS+1]) begin
                     rem_r <= shifted_s[REG_BUS-1:0];
                     quo_r <= {quo_r[REG_BUS-2:0], 1'b0};
                  end else begin
                     rem_r <= trial_s[REG_BUS-1:0];
                     quo_r <= {quo_r[REG_BUS-2:0], 1'b1};
                  end
                  cnt_r <= cnt_r + 6'd1;
               end else begin
                  result_r <= {cond_neg(sign && op1[REG_BUS-1], rem_r),
                               cond_neg(sign && (op1[REG_BUS-1] ^ op2[REG_BUS-1]), quo_r)};
                  cnt_r    <= 6'd0;
                  state_r  <= DIV_END;
               end
            end
            DIV_END: begin
               if (!en) begin
                  state_r <= DIV_FREE;
               end
            end
            default: state_r <= DIV_FREE;
         endcase
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for the EXE-stage divider: latches operands, stalls
// the pipeline, handles flush, and issues a single-cycle HI/LO write.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               sign,
   input  logic [REG_BUS-1:0] op1,
   input  logic [REG_BUS-1:0] op2,
   input  logic               flush,
   output logic               stall_req,
   output logic               busy,
   output logic               hilo_we,
   output logic [REG_BUS-1:0] hi_wdata,
   output logic [REG_BUS-1:0] lo_wdata,
   output logic               div_by_zero
);

   ctrl_state_t               state_r;
   logic                      sign_r;
   logic [REG_BUS-1:0]        op1_r;
   logic [REG_BUS-1:0]        op2_r;
   logic [1:0]                hold_cnt_r;
   logic                      in_busy_s;
   logic                      finish_s;
   logic                      div_en_s;
   logic                      div_cancel_s;
   logic                      div_done_s;
   logic [DOUBLE_REG_BUS-1:0] div_result_s;

   // Flush must drop enable and raise cancel within the same cycle.
   always_comb begin
      in_busy_s    = (state_r == CTRL_BUSY);
      div_en_s     = in_busy_s && !flush;
      div_cancel_s = in_busy_s && flush;
      finish_s     = in_busy_s && div_done_s && !flush;
   end

   assign stall_req   = start && !finish_s;
   assign busy        = (state_r != CTRL_IDLE);
   assign hilo_we     = finish_s;
   assign hi_wdata    = finish_s ? div_result_s[DOUBLE_REG_BUS-1:REG_BUS] : 32'd0;
   assign lo_wdata    = finish_s ? div_result_s[REG_BUS-1:0] : 32'd0;
   assign div_by_zero = finish_s && (op2_r == 32'd0);

   // Controller FSM and operand latches.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= CTRL_IDLE;
         sign_r     <= 1'b0;
         op1_r      <= 32'd0;
         op2_r      <= 32'd0;
         hold_cnt_r <= 2'd0;
      end else begin
         case (state_r)
            CTRL_IDLE: begin
               if (start && !flush) begin
                  sign_r  <= sign;
                  op1_r   <= op1;
                  op2_r   <= op2;
                  state_r <= CTRL_BUSY;
               end
            end
            CTRL_BUSY: begin
               if (flush) begin
                  hold_cnt_r <= DRAIN_CYCLES - 2'd1;
                  state_r    <= CTRL_DRAIN;
               end else if (div_done_s) begin
                  hold_cnt_r <= RELEASE_CYCLES - 2'd1;
                  state_r    <= CTRL_RELEASE;
               end
            end
            CTRL_RELEASE, CTRL_DRAIN: begin
               if (hold_cnt_r == 2'd0) begin
                  state_r <= CTRL_IDLE;
               end else begin
                  hold_cnt_r <= hold_cnt_r - 2'd1;
               end
            end
            default: state_r <= CTRL_IDLE;
         endcase
      end
   end

   div_ctrl_div u_div (
      .clk    (clk),
      .reset  (reset),
      .en     (div_en_s),
      .cancel (div_cancel_s),
      .sign   (sign_r),
      .op1    (op1_r),
      .op2    (op2_r),
      .result (div_result_s),
      .done   (div_done_s)
   );

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: stimulus pushes expected HI/LO writes,
// a negedge monitor pops and compares every write it observes.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        sign;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        flush;
   logic        stall_req;
   logic        busy;
   logic        hilo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;
   logic        div_by_zero;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   div_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .sign        (sign),
      .op1         (op1),
      .op2         (op2),
      .flush       (flush),
      .stall_req   (stall_req),
      .busy        (busy),
      .hilo_we     (hilo_we),
      .hi_wdata    (hi_wdata),
      .lo_wdata    (lo_wdata),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every observed write must match the oldest pending expectation.
   always @(negedge clk) begin
      if (hilo_we === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got hi=%h lo=%h expected no write (cycle %0d)",
                     hi_wdata, lo_wdata, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("hi_wdata", hi_wdata, e.hi);
            check("lo_wdata", lo_wdata, e.lo);
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            check("write_cycle", cyc, e.cyc);
         end
      end
   end

   // acc_dly: cycles from presenting start until the controller can accept it.
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         input int acc_dly, input bit garbage);
      int   t0;
      bit   seen;
      bit   stall_ok;
      exp_t e;
      t0    = cyc + acc_dly;
      e.hi  = ehi;
      e.lo  = elo;
      e.dbz = edbz;
      e.cyc = t0 + ((b == 32'd0) ? 3 : 35);
      sb.push_back(e);
      sign  = s;
      op1   = a;
      op2   = b;
      start = 1'b1;
      seen     = 1'b0;
      stall_ok = 1'b1;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         if (hilo_we === 1'b1) begin
            seen = 1'b1;
            check("stall_at_write", {31'd0, stall_req}, 32'd0);
         end else if (stall_req !== 1'b1) begin
            stall_ok = 1'b0;
         end
         if (garbage && cyc > t0) begin
            op1 = $urandom;
            op2 = $urandom;
         end
      end
      check("write_seen", {31'd0, seen}, 32'd1);
      check("stall_while_pending", {31'd0, stall_ok}, 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      op1   = 32'd0;
      op2   = 32'd0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_stall_req"}, {31'd0, stall_req}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_hilo_we"}, {31'd0, hilo_we}, 32'd0);
      check({tag, "_hi_wdata"}, hi_wdata, 32'd0);
      check({tag, "_lo_wdata"}, lo_wdata, 32'd0);
      check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      sign  = 1'b0;
      op1   = 32'd0;
      op2   = 32'd0;
      flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk);
      #1;
      reset = 1'b1;

      run_op(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 1'b0);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1, 1'b0);
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1, 1'b0);
      run_op(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1'b0);
      run_op(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1, 1'b0);
      run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 1'b0, 1, 1'b0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 1'b0, 1, 1'b1);

      // Flush at T10 of a signed divide; the next request waits out the drain.
      @(posedge clk);
      #1;
      sign  = 1'b1;
      op1   = 32'd100;
      op2   = 32'd3;
      start = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      run_op(1'b0, 32'd8, 32'd2, 32'd0, 32'd4, 1'b0, 2, 1'b0);

      // Reset at T20 of an operation: no write may ever appear for it.
      @(posedge clk);
      #1;
      sign  = 1'b0;
      op1   = 32'd1000;
      op2   = 32'd10;
      start = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("midop_reset");
      repeat (40) @(negedge clk);
      @(posedge clk);
      #1;
      run_op(1'b0, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0, 0, 1'b0);

      repeat (3) @(posedge clk);
      check("pending_expectations", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the EXE-stage multi-cycle divider. It accepts DIV/DIVU requests from the EXE stage and latches the operands. It holds the divider's enable high and the operands stable until the divider finishes, stalls the pipeline meanwhile, aborts on flush, and produces a one-cycle HI/LO write. It sits between EXE decode and the HI/LO register file, and it owns the divider instance.

## Interface
Parameters: none (widths from shared defines: RegBus 32 b, DoubleRegBus 64 b).
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- start  in  1  EXE holds a valid DIV/DIVU; level, held while stall_req=1
- sign  in  1  1 = DIV (signed), 0 = DIVU
- op1  in  32  dividend
- op2  in  32  divisor
- flush  in  1  exception/pipeline flush; abort current op
- stall_req  out  1  stall EXE and earlier stages
- busy  out  1  controller not in IDLE
- hilo_we  out  1  one-cycle HI/LO write strobe
- hi_wdata  out  32  remainder
- lo_wdata  out  32  quotient
- div_by_zero  out  1  valid with hilo_we; op2 was 0

## Operation
- States: IDLE, BUSY, RELEASE, DRAIN.
- IDLE: if start && !flush, latch sign/op1/op2 into internal registers and go to BUSY. Otherwise stay.
- BUSY: divider en=1 and cancel=0. Divider op inputs are driven only from the latched registers, because the divider re-reads operand signs at completion.
  - If flush: cancel=1, en=0 in the same cycle, no write, go to DRAIN.
  - Else if div_done: hilo_we=1, hi_wdata=result[63:32], lo_wdata=result[31:0], div_by_zero=(latched op2==0), go to RELEASE.
- RELEASE: en=0 for exactly 1 cycle so the divider returns to free, then go to IDLE.
- DRAIN: en=0 for exactly 2 cycles. This covers a cancel landing in the divide-by-zero path, which ignores cancel. Then go to IDLE.
- stall_req = start && !(state==BUSY && div_done && !flush). Equivalently, it stays high while a division is pending, including a new start arriving during RELEASE or DRAIN.
- Divide by zero: result is whatever the divider returns (0/0). The controller writes it with div_by_zero=1 and raises no exception.
- flush wins over div_done in the same cycle: no write.
- flush in IDLE with start: request not accepted, stall_req follows the formula.
- busy = (state != IDLE).

## Timing
- Reset (reset=0 at clk edge): state IDLE. stall_req=0, busy=0, hilo_we=0, hi_wdata=0, lo_wdata=0, div_by_zero=0. Latched operands and sign are 0, and divider en=0.
- start accepted in cycle T0 → BUSY from T1.
- Nonzero divisor: done seen at T35, hilo_we in T35. stall_req is high T0–T34 and low in T35.
- Zero divisor: done seen at T3, hilo_we in T3.
- After hilo_we: the earliest next acceptance is T+2 (RELEASE at T+1, IDLE at T+2). After flush at Tf, the earliest next acceptance is Tf+3.
- hilo_we is never high for more than 1 cycle per accepted request, and never high after a flush of that request.
- Reset mid-operation returns to IDLE in 1 cycle with no write. The divider is reset by the same signal.

## Structure
- State encodings (2 b) and the RELEASE/DRAIN lengths are constants in the shared defines header, next to the divider's state constants.
- One sub-module: the existing divider, instantiated inside div_ctrl. Its en, cancel, sign, op1 and op2 are driven only by div_ctrl.
- hi_wdata, lo_wdata and div_by_zero are registered or combinational from div result. They must be valid in the hilo_we cycle.

## Test plan
- DIVU 100/7: start at T0 → hilo_we at T35 only, hi=2, lo=14, stall_req high T0–T34.
- DIV -7/2 (0xFFFFFFF9/2): hi=0xFFFFFFFF, lo=0xFFFFFFFD. DIV 7/-2: hi=1, lo=0xFFFFFFFD.
- DIVU 5/0: hilo_we at T3 with div_by_zero=1. The next DIVU 9/3 issued back-to-back gives hi=0, lo=3.
- flush at T10 of a DIV: no hilo_we ever, stall_req drops with start. A new DIVU 8/2 started at T11 is accepted at T13 and writes lo=4, hi=0.
- op1/op2 inputs changed mid-operation (garbage after T0): the result matches the values latched at T0.
- reset=0 at T20 of an operation: all outputs 0 the next cycle, no hilo_we. A new request after reset completes correctly.
